// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs 32-bit big-endian words into 512-bit blocks, appends the
// 0x80 marker, zero fill and the 64-bit message bit length.
module sha256_padder #(
    parameter int unsigned LEN_W = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [2:0]   in_nbytes,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_first,
    output logic         blk_last
);

    typedef enum logic [1:0] {StFill, StPad, StLen, StEmit} state_e;

    state_e             state_q, state_d;
    logic [3:0]         widx_q, widx_d;
    logic [LEN_W-1:0]   bitlen_q, bitlen_d;
    logic [LEN_W-1:0]   nb_bits;
    logic               first_q, first_d;
    logic               mark_q, mark_d;
    logic               ovf_q, ovf_d;
    logic               run_q;
    logic [511:0]       blk_q, blk_d;
    logic               blk_first_q, blk_first_d;
    logic               blk_last_q, blk_last_d;
    logic [2:0]         nb;
    logic [31:0]        word;
    logic [63:0]        len64;
    logic [8:0]         wpos;
    logic               place;

    assign in_ready  = run_q && (state_q == StFill) && !mark_q;
    assign blk_valid = (state_q == StEmit);
    assign blk_data  = blk_q;
    assign blk_first = blk_first_q;
    assign blk_last  = blk_last_q;

    assign nb      = !in_last ? 3'd4 : (in_nbytes > 3'd4 ? 3'd4 : in_nbytes);
    assign nb_bits = LEN_W'({nb, 3'b000});
    assign len64   = 64'(bitlen_q);
    assign wpos    = {4'd15 - widx_q, 5'd0};

    always_comb begin
        unique case (nb)
            3'd0:    word = 32'h8000_0000;
            3'd1:    word = {in_data[31:24], 24'h80_0000};
            3'd2:    word = {in_data[31:16], 16'h8000};
            3'd3:    word = {in_data[31:8], 8'h80};
            default: word = in_data;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        widx_d      = widx_q;
        bitlen_d    = bitlen_q;
        first_d     = first_q;
        mark_d      = mark_q;
        ovf_d       = ovf_q;
        blk_d       = blk_q;
        blk_first_d = blk_first_q;
        blk_last_d  = blk_last_q;
        place       = 1'b0;
        unique case (state_q)
            StFill: begin
                if (mark_q) begin
                    blk_d[wpos +: 32] = 32'h8000_0000;
                    mark_d            = 1'b0;
                    place             = 1'b1;
                end else if (in_valid && in_ready) begin
                    blk_d[wpos +: 32] = word;
                    bitlen_d          = bitlen_q + nb_bits;
                    widx_d            = widx_q + 4'd1;
                    if (in_last && nb != 3'd4) begin
                        place = 1'b1;
                    end else begin
                        // A full last word defers its marker to the next word slot.
                        mark_d = in_last;
                        if (widx_q == 4'd15) state_d = StEmit;
                    end
                end
                // Marker landed at widx_q: decide whether the length still fits in this block.
                if (place) begin
                    widx_d = widx_q + 4'd1;
                    if (widx_q == 4'd15) begin
                        state_d = StEmit;
                        ovf_d   = 1'b1;
                    end else if (widx_q == 4'd14) begin
                        state_d = StPad;
                        ovf_d   = 1'b1;
                    end else if (widx_q == 4'd13) begin
                        state_d = StLen;
                    end else begin
                        state_d = StPad;
                    end
                end
            end
            StPad: begin
                if (!ovf_q && widx_q == 4'd14) begin
                    state_d = StLen;
                end else begin
                    blk_d[wpos +: 32] = '0;
                    widx_d            = widx_q + 4'd1;
                    if (widx_q == 4'd15) state_d = StEmit;
                end
            end
            StLen: begin
                blk_d[63:0] = len64;
                state_d     = StEmit;
            end
            StEmit: begin
                if (blk_ready) begin
                    widx_d  = '0;
                    state_d = ovf_q ? StPad : StFill;
                    ovf_d   = 1'b0;
                    first_d = blk_last_q;
                    if (blk_last_q) bitlen_d = '0;
                end
            end
            default: state_d = StFill;
        endcase
        if (state_d == StEmit && state_q != StEmit) begin
            blk_first_d = first_q;
            blk_last_d  = (state_q == StLen);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StFill;
            widx_q      <= '0;
            bitlen_q    <= '0;
            first_q     <= 1'b1;
            mark_q      <= 1'b0;
            ovf_q       <= 1'b0;
            run_q       <= 1'b0;
            blk_q       <= '0;
            blk_first_q <= 1'b0;
            blk_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            widx_q      <= widx_d;
            bitlen_q    <= bitlen_d;
            first_q     <= first_d;
            mark_q      <= mark_d;
            ovf_q       <= ovf_d;
            run_q       <= 1'b1;
            blk_q       <= blk_d;
            blk_first_q <= blk_first_d;
            blk_last_q  <= blk_last_d;
        end
    end

endmodule

// File: doc/sha256_padder.md
SHA256_PADDER -- requirements
Module: sha256_padder

Interface
REQ-001 SHALL have parameter LEN_W, default 64, width of the internal message bit-length counter; bits 63:LEN_W of the length field are zero.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  input word valid.
REQ-005 SHALL have port in_ready  output  1  padder accepts an input word this cycle.
REQ-006 SHALL have port in_data  input  32  message word, big-endian; byte0 = bits 31:24.
REQ-007 SHALL have port in_last  input  1  the current word is the final message word.
REQ-008 SHALL have port in_nbytes  input  3  number of valid bytes in the last word, 0..4; ignored (treated as 4) when in_last=0.
REQ-009 SHALL have port blk_valid  output  1  padded 512-bit block available.
REQ-010 SHALL have port blk_ready  input  1  downstream hash unit takes the block.
REQ-011 SHALL have port blk_data  output  512  block; word0 in bits 511:480, word15 in bits 31:0.
REQ-012 SHALL have port blk_first  output  1  block is the first block of a message; the consumer loads its initial hash.
REQ-013 SHALL have port blk_last  output  1  block is the final block of a message.

Function
REQ-014 SHALL implement states FILL, PAD, LEN, EMIT.
REQ-015 FILL: in_ready=1; each handshake (in_valid&in_ready) writes the word at index widx, increments widx, and adds 8*nbytes to bitlen (LEN_W bits, wraps modulo 2^LEN_W).
REQ-016 Last word: bytes at positions >= in_nbytes SHALL be zeroed. If in_nbytes<4, 0x80 goes into byte position in_nbytes of the same word. If in_nbytes=4, the next cycle writes 0x80000000 at the next index.
REQ-017 in_nbytes=0 with in_last=1 SHALL be legal; the stored word becomes 0x80000000 (empty message when it is the first word).
REQ-018 A non-last handshake at widx=15 SHALL go to EMIT with blk_last=0.
REQ-019 PAD: in_ready=0; writes one zero word per cycle until widx=14, then goes to LEN.
REQ-020 Overflow: if the 0x80 marker lands in word 14 or 15, PAD SHALL zero-fill to word 15 and emit (blk_last=0). A following block of words 0..13 = 0 is then built in PAD/LEN.
REQ-021 LEN: in a single cycle, writes word14 = bitlen[63:32] and word15 = bitlen[31:0], then goes to EMIT with blk_last=1.
REQ-022 EMIT: blk_valid=1 and in_ready=0; blk_data, blk_first and blk_last SHALL hold stable while blk_ready=0.
REQ-023 On the EMIT handshake: widx is cleared. The next state is FILL if the message continues or has completed, otherwise PAD (overflow pending). After blk_last, bitlen and the first flag are cleared.
REQ-024 blk_first SHALL be 1 only on the first emitted block after reset or after a blk_last handshake.
REQ-025 Latency: a last word accepted at index k<=13 gives blk_valid no earlier than (13-k)+2 cycles later; the bench checks content, not exact cycle count beyond this bound.
REQ-026 in_valid while in_ready=0 SHALL be ignored; no word is lost or duplicated.

Reset
REQ-027 While reset_n=0 at a clock edge, all of the following SHALL be cleared: state=FILL, widx=0, bitlen=0, first flag=1, blk_valid=0, blk_data=0, blk_first=0, blk_last=0, in_ready=0.
REQ-028 in_ready SHALL be 1 on the first cycle after reset_n returns high.
REQ-029 Reset mid-message or mid-EMIT SHALL discard the partial block; no blk_valid until new input arrives.

Verification
REQ-030 "abc": one word 0x61626300, last, nbytes=3 -> one block: w0=0x61626380, w1..w14=0, w15=0x00000018, first=last=1.
REQ-031 Empty message: word, last, nbytes=0 -> w0=0x80000000, w1..w15=0, first=last=1.
REQ-032 55 bytes: 14 words, last nbytes=3 -> one block: w13 low byte=0x80, w14=0, w15=0x000001B8.
REQ-033 56 bytes: 14 words, last nbytes=4 -> block1 with w14=0x80000000, w15=0, last=0; block2 with w0..w13=0, w15=0x000001C0, first=0, last=1.
REQ-034 64 bytes under blk_ready held low for 10 cycles -> block1 = data, stable for the whole stall; block2 w0=0x80000000, w15=0x00000200.
REQ-035 reset_n low for one cycle after 5 words -> then "abc" -> exactly one block, as in REQ-030, with blk_first=1.
